// File: rtl/bmu_clmul_iter_pkg.sv
// Shared types and constants for the iterative Zbc carry-less multiplier.
package bmu_clmul_iter_pkg;

  typedef struct packed {
    int unsigned XLEN;
  } cvw_t;

  localparam cvw_t CVW_RV64 = '{XLEN: 32'd64};
  localparam cvw_t CVW_RV32 = '{XLEN: 32'd32};

  typedef enum logic [1:0] {
    CLMUL_IDLE = 2'b00,
    CLMUL_RUN  = 2'b01,
    CLMUL_DONE = 2'b10
  } clmulstate_t;

  localparam logic [2:0] FUNCT3_CLMUL  = 3'b001;
  localparam logic [2:0] FUNCT3_CLMULH = 3'b011;
  localparam logic [2:0] FUNCT3_CLMULR = 3'b010;

  // Encodings the decoder never issues collapse onto plain clmul.
  function automatic logic [2:0] legal_funct3(input logic [2:0] f);
    case (f)
      FUNCT3_CLMULH: legal_funct3 = FUNCT3_CLMULH;
      FUNCT3_CLMULR: legal_funct3 = FUNCT3_CLMULR;
      default:       legal_funct3 = FUNCT3_CLMUL;
    endcase
  endfunction

endpackage

// File: rtl/bmu_clmul_iter_clmulstep.sv
// One iteration of the carry-less multiply: XOR BPC shifted multiplicand copies into the accumulator.
module bmu_clmul_iter_clmulstep #(
  parameter int W   = 128,
  parameter int BPC = 8
) (
  input  logic [W-1:0]   acc,
  input  logic [W-1:0]   a,
  input  logic [BPC-1:0] b,
  output logic [W-1:0]   acc_next
);

  // Partial-product accumulation for the BPC multiplier bits retired this cycle.
  always_comb begin
    acc_next = acc;
    for (int j = 0; j < BPC; j++) begin
      if (b[j]) begin
        acc_next = acc_next ^ (a << j);
      end else begin
        acc_next = acc_next;
      end
    end
  end

endmodule

// File: rtl/bmu_clmul_iter.sv
// Iterative carry-less multiplier (clmul/clmulh/clmulr) for the Execute-stage bit-manipulation unit.
module bmu_clmul_iter
  import bmu_clmul_iter_pkg::*;
#(
  parameter cvw_t P   = CVW_RV64,
  parameter int   BPC = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    StartE,
  input  logic                    FlushE,
  input  logic                    StallM,
  input  logic [2:0]              Funct3E,
  input  logic [int'(P.XLEN)-1:0] AE,
  input  logic [int'(P.XLEN)-1:0] BE,
  output logic                    BusyE,
  output logic                    DoneE,
  output logic [int'(P.XLEN)-1:0] ResultE
);

  localparam int XLEN = int'(P.XLEN);
  localparam int N    = XLEN / BPC;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  clmulstate_t         state_r, state_s;
  logic [2*XLEN-1:0]   a_r, a_s, acc_r, acc_s, step_s;
  logic [XLEN-1:0]     b_r, b_s;
  logic [2:0]          f3_r, f3_s;
  logic [CW-1:0]       cnt_r, cnt_s;
  logic                load_s;

  bmu_clmul_iter_clmulstep #(.W(2*XLEN), .BPC(BPC)) u_step (
    .acc      (acc_r),
    .a        (a_r),
    .b        (b_r[BPC-1:0]),
    .acc_next (step_s)
  );

  assign load_s = ~FlushE & StartE &
                  ((state_r == CLMUL_IDLE) | ((state_r == CLMUL_DONE) & ~StallM));

  // Next-state and datapath update; flush outranks every other transition.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    f3_s    = f3_r;
    acc_s   = acc_r;
    cnt_s   = cnt_r;
    if (FlushE) begin
      state_s = CLMUL_IDLE;
      acc_s   = '0;
      cnt_s   = '0;
    end else if (load_s) begin
      state_s = CLMUL_RUN;
      a_s     = {{XLEN{1'b0}}, AE};
      b_s     = BE;
      f3_s    = legal_funct3(Funct3E);
      acc_s   = '0;
      cnt_s   = '0;
    end else begin
      case (state_r)
        CLMUL_RUN: begin
          acc_s = step_s;
          a_s   = a_r << BPC;
          b_s   = b_r >> BPC;
          if (cnt_r == LAST) begin
            cnt_s   = '0;
            state_s = CLMUL_DONE;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end
        CLMUL_DONE: begin
          if (!StallM) begin
            state_s = CLMUL_IDLE;
          end else begin
            state_s = CLMUL_DONE;
          end
        end
        CLMUL_IDLE: state_s = CLMUL_IDLE;
        default:    state_s = CLMUL_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= CLMUL_IDLE;
      a_r     <= '0;
      b_r     <= '0;
      f3_r    <= FUNCT3_CLMUL;
      acc_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      f3_r    <= f3_s;
      acc_r   <= acc_s;
      cnt_r   <= cnt_s;
    end
  end

  assign BusyE = ((state_r == CLMUL_IDLE) & StartE) |
                 (state_r == CLMUL_RUN) |
                 ((state_r == CLMUL_DONE) & ~StallM & StartE);
  assign DoneE = (state_r == CLMUL_DONE);

  // Product slice selection, forced to zero outside DONE.
  always_comb begin
    ResultE = '0;
    if (DoneE) begin
      case (f3_r)
        FUNCT3_CLMULH: ResultE = acc_r[2*XLEN-1:XLEN];
        FUNCT3_CLMULR: ResultE = acc_r[2*XLEN-2:XLEN-1];
        default:       ResultE = acc_r[XLEN-1:0];
      endcase
    end else begin
      ResultE = '0;
    end
  end

endmodule

// File: tb/tb_bmu_clmul_iter.sv
// Directed scoreboard bench for bmu_clmul_iter at XLEN=64/BPC=8 and XLEN=32/BPC=1.
module tb_bmu_clmul_iter;
  import bmu_clmul_iter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start64 = 1'b0, start32 = 1'b0;
  logic        FlushE = 1'b0, StallM = 1'b0;
  logic [2:0]  f3 = 3'b001;
  logic [63:0] a = 64'd0, b = 64'd0;
  logic        busy64, done64, busy32, done32;
  logic [63:0] res64;
  logic [31:0] res32;

  int checks = 0;
  int passes = 0;
  logic busy_at_start;
  logic [63:0] q64[$];
  logic [63:0] q32[$];

  always #5 clk = ~clk;

  bmu_clmul_iter #(.P(CVW_RV64), .BPC(8)) dut64 (
    .clk(clk), .reset(reset), .StartE(start64), .FlushE(FlushE), .StallM(StallM),
    .Funct3E(f3), .AE(a), .BE(b), .BusyE(busy64), .DoneE(done64), .ResultE(res64)
  );

  bmu_clmul_iter #(.P(CVW_RV32), .BPC(1)) dut32 (
    .clk(clk), .reset(reset), .StartE(start32), .FlushE(FlushE), .StallM(StallM),
    .Funct3E(f3), .AE(a[31:0]), .BE(b[31:0]), .BusyE(busy32), .DoneE(done32), .ResultE(res32)
  );

  function automatic logic [63:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic [2:0] op, input int xlen);
    logic [127:0] p, xm;
    logic [63:0]  mask;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    xm = {64'd0, x & mask};
    p = 128'd0;
    for (int i = 0; i < xlen; i++) if (y[i]) p = p ^ (xm << i);
    case (op)
      3'b011:  p = p >> xlen;
      3'b010:  p = p >> (xlen - 1);
      default: p = p;
    endcase
    return p[63:0] & mask;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy64 : busy32;
  endfunction
  function automatic logic done_of(input int sel);
    return (sel == 0) ? done64 : done32;
  endfunction
  function automatic logic [63:0] res_of(input int sel);
    return (sel == 0) ? res64 : {32'd0, res32};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Called just after a negedge: drives one op and records its expected result.
  task automatic start_op(input int sel, input logic [63:0] x, input logic [63:0] y,
                          input logic [2:0] op);
    a = x; b = y; f3 = op;
    if (sel == 0) begin
      start64 = 1'b1;
      q64.push_back(model(x, y, op, 64));
    end else begin
      start32 = 1'b1;
      q32.push_back(model(x, y, op, 32));
    end
    #1 busy_at_start = busy_of(sel);
  endtask

  task automatic wait_done(input int sel, input int exp_cyc, input string tag);
    int cyc;
    int busy_cnt;
    logic [63:0] exp;
    cyc = 0;
    busy_cnt = busy_at_start ? 1 : 0;
    while (cyc < 200) begin
      @(negedge clk);
      start64 = 1'b0; start32 = 1'b0;
      #1 cyc++;
      if (done_of(sel)) break;
      busy_cnt += busy_of(sel) ? 1 : 0;
    end
    check({tag, " latency"}, 64'(cyc), 64'(exp_cyc));
    check({tag, " busy cycles"}, 64'(busy_cnt), 64'(exp_cyc));
    check({tag, " busy at done"}, {63'd0, busy_of(sel)}, 64'd0);
    if (sel == 0) exp = (q64.size() > 0) ? q64.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    else          exp = (q32.size() > 0) ? q32.pop_front() : 64'hDEAD_DEAD_DEAD_DEAD;
    check({tag, " result"}, res_of(sel), exp);
  endtask

  initial begin
    logic [63:0] held;
    logic        seen;

    #1;
    check("reset busy", {63'd0, busy64}, 64'd0);
    check("reset done", {63'd0, done64}, 64'd0);
    check("reset result", res64, 64'd0);
    @(negedge clk); reset = 1'b1;

    // clmul 3*3 = 5, then IDLE the following cycle
    @(negedge clk); start_op(0, 64'd3, 64'd3, 3'b001);
    wait_done(0, 9, "clmul3x3");
    check("clmul3x3 const", res64, 64'd5);
    @(negedge clk); #1;
    check("idle after done", {63'd0, done64}, 64'd0);
    check("idle result zero", res64, 64'd0);

    // top-bit products for all three slices
    @(negedge clk); start_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b001);
    wait_done(0, 9, "msb clmul");
    check("msb clmul const", res64, 64'd0);
    @(negedge clk); start_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b011);
    wait_done(0, 9, "msb clmulh");
    check("msb clmulh const", res64, 64'h4000_0000_0000_0000);
    @(negedge clk); start_op(0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'b010);
    wait_done(0, 9, "msb clmulr");
    check("msb clmulr const", res64, 64'h8000_0000_0000_0000);

    // random operands across legal and unsupported funct3 codes
    for (int k = 0; k < 5; k++) begin
      logic [2:0] ops [5];
      ops = '{3'b001, 3'b011, 3'b010, 3'b000, 3'b101};
      @(negedge clk);
      start_op(0, {$urandom, $urandom}, {$urandom, $urandom}, ops[k]);
      wait_done(0, 9, "rand64");
    end

    // flush in the third RUN cycle
    @(negedge clk); start_op(0, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0F0F_0F0F_0F0F, 3'b001);
    repeat (2) begin @(negedge clk); start64 = 1'b0; end
    @(negedge clk); FlushE = 1'b1;
    @(negedge clk); FlushE = 1'b0;
    #1;
    check("flush busy", {63'd0, busy64}, 64'd0);
    check("flush done", {63'd0, done64}, 64'd0);
    void'(q64.pop_back());
    seen = 1'b0;
    repeat (15) begin @(negedge clk); #1 seen = seen | done64; end
    check("flush never done", {63'd0, seen}, 64'd0);

    // stall holds the result in DONE
    @(negedge clk); StallM = 1'b1;
    start_op(0, 64'hCAFE_BABE_0000_1111, 64'h0000_0000_8421_8421, 3'b011);
    wait_done(0, 9, "stall");
    held = res64;
    repeat (3) begin
      @(negedge clk); #1;
      check("stall done held", {63'd0, done64}, 64'd1);
      check("stall result held", res64, held);
    end
    StallM = 1'b0;
    @(negedge clk); #1;
    check("idle after stall", {63'd0, done64}, 64'd0);

    // back-to-back start from DONE
    @(negedge clk); start_op(0, 64'hFFFF_0000_FFFF_0000, 64'h0000_00FF_0000_00FF, 3'b001);
    wait_done(0, 9, "b2b first");
    start_op(0, 64'hFF, 64'hFF, 3'b001);
    check("b2b busy at restart", {63'd0, busy_at_start}, 64'd1);
    wait_done(0, 9, "b2b second");
    check("b2b second const", res64, 64'h5555);

    // reset mid-RUN, then a fresh op
    @(negedge clk); start_op(0, 64'h7777, 64'h3333, 3'b001);
    repeat (4) begin @(negedge clk); start64 = 1'b0; end
    reset = 1'b0;
    #1;
    check("rst64 busy", {63'd0, busy64}, 64'd0);
    check("rst64 done", {63'd0, done64}, 64'd0);
    check("rst64 result", res64, 64'd0);
    void'(q64.pop_back());
    @(negedge clk); reset = 1'b1;
    @(negedge clk); #1;
    check("rst64 no done", {63'd0, done64}, 64'd0);
    start_op(0, 64'hA5A5_5A5A_A5A5_5A5A, 64'h0000_0001_0000_0003, 3'b010);
    wait_done(0, 9, "post-rst64");

    // XLEN=32, BPC=1
    @(negedge clk); start_op(1, 64'd3, 64'd3, 3'b001);
    wait_done(1, 33, "x32 3x3");
    check("x32 3x3 const", {32'd0, res32}, 64'd5);
    @(negedge clk); start_op(1, 64'h8000_0000, 64'h8000_0000, 3'b011);
    wait_done(1, 33, "x32 msb clmulh");
    check("x32 msb clmulh const", {32'd0, res32}, 64'h4000_0000);
    @(negedge clk); start_op(1, 64'(unsigned'($urandom)), 64'(unsigned'($urandom)), 3'b010);
    repeat (10) begin @(negedge clk); start32 = 1'b0; end
    reset = 1'b0;
    #1;
    check("rst32 busy", {63'd0, busy32}, 64'd0);
    check("rst32 done", {63'd0, done32}, 64'd0);
    check("rst32 result", {32'd0, res32}, 64'd0);
    void'(q32.pop_back());
    @(negedge clk); reset = 1'b1;
    @(negedge clk); start_op(1, 64'h0000_0000_DEAD_BEEF, 64'h0000_0000_1357_9BDF, 3'b010);
    wait_done(1, 33, "post-rst32");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
